mem_port_arb: RTL



---
 rtl/mem_port_arb_pkg.sv | 20 ++
 rtl/mem_port_arb.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_port_arb_pkg;

  // Sequencer states for the single outstanding bus transaction.
  typedef enum logic [1:0] {
    MARB_ST_IDLE = 2'd0,
    MARB_ST_ADDR = 2'd1,
    MARB_ST_DATA = 2'd2
  } marb_state_e;

  // Owner of the transaction currently on the bus.
  localparam logic MARB_OWN_IF = 1'b0;
  localparam logic MARB_OWN_DM = 1'b1;

  // Saturating increment for the 3-bit starvation counter.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/mem_port_arb.sv
// Arbiter/sequencer for the shared memory port: fetch (IF1) and load/store (MM1)
// requesters, one outstanding req/addr_ok/data_ok transaction, response routing
// and dropping of fetch responses cancelled by a redirect.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_cancel,
  output logic        if_rdy,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_wstrb,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_rdy,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam logic [2:0] StarveLim = 3'(STARVE_MAX);

  marb_state_e state_q, state_d;
  logic        own_dm_q;
  logic        we_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  starve_q;
  logic        drop_q;
  logic        if_rvalid_q, dm_rvalid_q;
  logic [31:0] if_rdata_q, dm_rdata_q;

  logic idle, if_win, dm_win, done, if_drop;

  // Grant arbitration and next-state logic
  always_comb begin
    idle    = (state_q == MARB_ST_IDLE);
    // Data wins a contested grant unless fetch has been starved long enough.
    if_win  = idle & if_req & (~dm_req | (starve_q == StarveLim));
    dm_win  = idle & dm_req & ~if_win;
    done    = ((state_q == MARB_ST_ADDR) & bus_addr_ok & bus_data_ok) |
              ((state_q == MARB_ST_DATA) & bus_data_ok);
    // A redirect arriving in the completion cycle still kills the response.
    if_drop = drop_q | if_cancel;
    state_d = state_q;
    unique case (state_q)
      MARB_ST_IDLE: if (if_win | dm_win) state_d = MARB_ST_ADDR;
      MARB_ST_ADDR: if (bus_addr_ok) state_d = bus_data_ok ? MARB_ST_IDLE : MARB_ST_DATA;
      MARB_ST_DATA: if (bus_data_ok) state_d = MARB_ST_IDLE;
      default:      state_d = MARB_ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= MARB_ST_IDLE;
    else         state_q <= state_d;
  end

  // Latch owner and payload of the granted request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      own_dm_q <= MARB_OWN_IF;
      we_q     <= 1'b0;
      wstrb_q  <= 4'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
    end else if (if_win) begin
      own_dm_q <= MARB_OWN_IF;
      we_q     <= 1'b0;
      wstrb_q  <= 4'h0;
      addr_q   <= if_addr;
      wdata_q  <= 32'h0;
    end else if (dm_win) begin
      own_dm_q <= MARB_OWN_DM;
      we_q     <= dm_we;
      wstrb_q  <= dm_wstrb;
      addr_q   <= dm_addr;
      wdata_q  <= dm_wdata;
    end
  end

  // Count contested grants lost by fetch; any fetch grant clears the count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               starve_q <= 3'd0;
    else if (if_win)           starve_q <= 3'd0;
    else if (dm_win && if_req) starve_q <= sat_inc3(starve_q);
  end

  // Remember a redirect that hit an in-flight fetch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                         drop_q <= 1'b0;
    else if (done)                                       drop_q <= 1'b0;
    else if (!idle && own_dm_q == MARB_OWN_IF && if_cancel) drop_q <= 1'b1;
  end

  // Register the response and route it to the owner
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'h0;
      dm_rdata_q  <= 32'h0;
    end else begin
      if_rvalid_q <= done & (own_dm_q == MARB_OWN_IF) & ~if_drop;
      dm_rvalid_q <= done & (own_dm_q == MARB_OWN_DM);
      if (done && own_dm_q == MARB_OWN_DM)             dm_rdata_q <= bus_rdata;
      if (done && own_dm_q == MARB_OWN_IF && !if_drop) if_rdata_q <= bus_rdata;
    end
  end

  assign if_rdy    = if_win;
  assign dm_rdy    = dm_win;
  assign bus_req   = (state_q == MARB_ST_ADDR);
  assign bus_we    = we_q;
  assign bus_wstrb = wstrb_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule
